// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty UART instruction loader.
package bitty_pkg;

    localparam int INSTR_W        = 16;
    localparam int UART_DATA_BITS = 8;
    localparam int BIT_IDX_W      = $clog2(UART_DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    typedef enum logic {
        PHASE_LOW  = 1'b0,
        PHASE_HIGH = 1'b1
    } byte_phase_t;

    function automatic logic [INSTR_W-1:0] make_word(
        input logic [UART_DATA_BITS-1:0] hi,
        input logic [UART_DATA_BITS-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/bitty_uart_byte_rx.sv
// 8N1 byte receiver: rx synchroniser, bit-timing FSM and shift register.
module bitty_uart_byte_rx
    import bitty_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] byte_o,
    output logic                      byte_valid_o,
    output logic                      frame_err_o,
    output logic                      busy_o
);

    localparam logic [CNT_W-1:0]     HALF_C     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]     LAST_C     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT_C = BIT_IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_t            state_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [BIT_IDX_W-1:0]      bit_idx_r;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic                      rx_meta_r;
    logic                      rx_s;
    logic                      rx_prev_r;
    logic                      busy_r;
    logic                      stop_hit_s;

    // Stop-bit sample strobe; the top consumes the byte on this same cycle.
    always_comb begin
        stop_hit_s = 1'b0;
        if ((state_r == STOP) && (cnt_r == LAST_C)) begin
            stop_hit_s = 1'b1;
        end else begin
            stop_hit_s = 1'b0;
        end
    end

    assign byte_o       = shift_r;
    assign byte_valid_o = stop_hit_s & rx_s;
    assign frame_err_o  = stop_hit_s & ~rx_s;
    assign busy_o       = busy_r;

    // Synchroniser, edge history and the frame FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_r <= 1'b1;
            state_r   <= IDLE;
            cnt_r     <= '0;
            bit_idx_r <= '0;
            shift_r   <= '0;
            busy_r    <= 1'b0;
        end else begin
            rx_meta_r <= rx_i;
            rx_s      <= rx_meta_r;
            rx_prev_r <= rx_s;
            case (state_r)
                IDLE: begin
                    // A falling edge needs the line high first, so a low stop bit cannot retrigger.
                    if (rx_prev_r && !rx_s) begin
                        state_r <= START;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_r == HALF_C) begin
                        cnt_r <= '0;
                        if (!rx_s) begin
                            state_r   <= DATA;
                            bit_idx_r <= '0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == LAST_C) begin
                        shift_r[bit_idx_r] <= rx_s;
                        cnt_r              <= '0;
                        if (bit_idx_r == LAST_BIT_C) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + BIT_IDX_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_r == LAST_C) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bitty_uart_instr_rx.sv
// UART instruction loader: pairs received bytes into 16-bit words and queues
// them in a small FIFO presented to the bitty core over valid/ready.
module bitty_uart_instr_rx
    import bitty_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic               frame_err_o,
    output logic               overrun_o,
    output logic               busy_o
);

    localparam int             PTR_W  = $clog2(FIFO_DEPTH);
    localparam int             CNT_FW = PTR_W + 1;
    localparam logic [PTR_W:0] FULL_C = CNT_FW'(FIFO_DEPTH);

    logic [UART_DATA_BITS-1:0] byte_s;
    logic                      byte_valid_s;
    logic                      frame_err_s;

    byte_phase_t               phase_r;
    logic [UART_DATA_BITS-1:0] byte0_r;
    logic [INSTR_W-1:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [PTR_W:0]            count_r;
    logic [INSTR_W-1:0]        last_r;
    logic                      frame_err_r;
    logic                      overrun_r;

    logic                      push_s;
    logic                      pop_s;
    logic                      push_ok_s;
    logic [INSTR_W-1:0]        word_s;

    bitty_uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_byte_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .byte_o       (byte_s),
        .byte_valid_o (byte_valid_s),
        .frame_err_o  (frame_err_s),
        .busy_o       (busy_o)
    );

    assign instr_valid_o = (count_r != '0);
    assign frame_err_o   = frame_err_r;
    assign overrun_o     = overrun_r;

    // Word completion, handshake and FIFO acceptance decisions.
    always_comb begin
        word_s    = make_word(byte_s, byte0_r);
        push_s    = 1'b0;
        pop_s     = 1'b0;
        push_ok_s = 1'b0;
        if (byte_valid_s && (phase_r == PHASE_HIGH)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_s = instr_valid_o & instr_ready_i;
        // A full FIFO still takes the word when the head leaves on the same edge.
        if (push_s && ((count_r < FULL_C) || pop_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Head is read straight from storage; an empty FIFO shows the last word popped.
    always_comb begin
        instr_o = last_r;
        if (instr_valid_o) begin
            instr_o = mem_r[rd_ptr_r];
        end else begin
            instr_o = last_r;
        end
    end

    // Byte phase, FIFO storage/pointers and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r     <= PHASE_LOW;
            byte0_r     <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            last_r      <= '0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            frame_err_r <= frame_err_s;
            overrun_r   <= push_s & ~push_ok_s;

            // A bad frame drops any half-built word so the next byte is a low byte.
            if (frame_err_s) begin
                phase_r <= PHASE_LOW;
            end else if (byte_valid_s) begin
                if (phase_r == PHASE_LOW) begin
                    byte0_r <= byte_s;
                    phase_r <= PHASE_HIGH;
                end else begin
                    phase_r <= PHASE_LOW;
                end
            end

            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                last_r   <= mem_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end

            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_FW'(1);
                2'b01:   count_r <= count_r - CNT_FW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_uart_instr_rx.sv
// Self-checking bench for bitty_uart_instr_rx with a queue-based word model.
module tb_bitty_uart_instr_rx;

    localparam int CPB   = 4;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] instr;
    logic        valid;
    logic        ready;
    logic        ferr;
    logic        ovr;
    logic        busy;

    bitty_uart_instr_rx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (3),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_i          (rx),
        .instr_o       (instr),
        .instr_valid_o (valid),
        .instr_ready_i (ready),
        .frame_err_o   (ferr),
        .overrun_o     (ovr),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observed activity
    logic [15:0] got_q[$];
    int n_ferr = 0;
    int n_ovr  = 0;
    int n_busy = 0;

    // reference model
    logic [15:0] m_fifo[$];
    logic [15:0] exp_pop[$];
    logic [7:0]  m_low = 8'h00;
    bit          m_hi = 1'b0;
    int          exp_ferr = 0;
    int          exp_ovr  = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) got_q.push_back(instr);
            if (ferr) n_ferr <= n_ferr + 1;
            if (ovr)  n_ovr  <= n_ovr + 1;
            if (busy) n_busy <= n_busy + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flush_model();
        while (m_fifo.size() > 0) exp_pop.push_back(m_fifo.pop_front());
    endtask

    task automatic set_ready(input logic v);
        ready = v;
        if (v) flush_model();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic rdy_pulse);
        logic [15:0] w;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
        if (rdy_pulse) begin
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
            tick(CPB - 1);
        end else begin
            tick(CPB);
        end
        if (!stop_ok) begin
            m_hi = 1'b0;
            exp_ferr++;
        end else if (!m_hi) begin
            m_low = b;
            m_hi  = 1'b1;
        end else begin
            w    = {b, m_low};
            m_hi = 1'b0;
            if (rdy_pulse && m_fifo.size() > 0) exp_pop.push_back(m_fifo.pop_front());
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else exp_ovr++;
            if (ready) flush_model();
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        ready = 1'b1;
        while (valid && n < 50) begin
            tick(1);
            n++;
        end
        ready = 1'b0;
        check({tag, "_drain_bound"}, 32'(n < 50), 32'd1);
        flush_model();
    endtask

    task automatic compare_all(input string tag);
        tick(6);
        check({tag, "_pops"}, got_q.size(), exp_pop.size());
        for (int i = 0; i < exp_pop.size(); i++) begin
            if (i < got_q.size()) check({tag, "_word"}, {16'h0, got_q[i]}, {16'h0, exp_pop[i]});
        end
        check({tag, "_frame_err"}, n_ferr, exp_ferr);
        check({tag, "_overrun"}, n_ovr, exp_ovr);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_instr"}, {16'h0, instr}, 32'h0);
        check({tag, "_valid"}, {31'h0, valid}, 32'h0);
        check({tag, "_ferr"},  {31'h0, ferr},  32'h0);
        check({tag, "_ovr"},   {31'h0, ovr},   32'h0);
        check({tag, "_busy"},  {31'h0, busy},  32'h0);
    endtask

    initial begin
        int stable;
        int n;
        int busy0;
        logic [7:0] b0;
        logic [7:0] b1;
        rx    = 1'b1;
        ready = 1'b0;
        rst_n = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // 1: ready held high, one word through
        set_ready(1'b1);
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        compare_all("t1");
        check("t1_value", {16'h0, got_q[got_q.size()-1]}, 32'h1234);
        set_ready(1'b0);

        // 2: back-pressure keeps the head stable
        send_byte(8'hEF, 1'b1, 1'b0);
        send_byte(8'hBE, 1'b1, 1'b0);
        n = 0;
        while (!valid && n < 100) begin
            tick(1);
            n++;
        end
        check("t2_valid_bound", 32'(n < 100), 32'd1);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid && instr == 16'hBEEF) stable++;
            tick(1);
        end
        check("t2_hold", stable, 20);
        check("t2_no_pop", got_q.size(), exp_pop.size());
        drain("t2");
        compare_all("t2");
        check("t2_valid_low", {31'h0, valid}, 32'h0);

        // 3: short glitch is rejected
        busy0 = n_busy;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(12);
        check("t3_busy_low", {31'h0, busy}, 32'h0);
        check("t3_busy_seen", 32'(n_busy > busy0), 32'd1);
        check("t3_valid", {31'h0, valid}, 32'h0);
        compare_all("t3");

        // 4: framing error resets the byte phase
        set_ready(1'b1);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'hCD, 1'b1, 1'b0);
        send_byte(8'hAB, 1'b1, 1'b0);
        compare_all("t4");
        check("t4_value", {16'h0, got_q[got_q.size()-1]}, 32'hABCD);
        set_ready(1'b0);

        // 5: overrun on the third word
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        compare_all("t5_fill");
        drain("t5");
        compare_all("t5");
        check("t5_valid_low", {31'h0, valid}, 32'h0);
        check("t5_hold_last", {16'h0, instr}, 32'h2222);

        // 6: full FIFO with a pop on the push cycle
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        send_byte(8'h03, 1'b1, 1'b0);
        send_byte(8'h04, 1'b1, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        send_byte(8'h44, 1'b1, 1'b1);
        compare_all("t6_push");
        drain("t6");
        compare_all("t6");

        // random bytes, ready levels and occasional bad stop bits
        for (int r = 0; r < 6; r++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            set_ready(1'($urandom_range(0, 1)));
            send_byte(b0, 1'($urandom_range(0, 5) != 0), 1'b0);
            send_byte(b1, 1'b1, 1'b0);
        end
        drain("rnd");
        compare_all("rnd");

        // 7: reset in the middle of the high byte
        set_ready(1'b0);
        send_byte(8'h9A, 1'b1, 1'b0);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = 1'($urandom_range(0, 1));
            tick(CPB);
        end
        rst_n = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(1);
        m_hi = 1'b0;
        m_fifo.delete();
        rst_n = 1'b1;
        tick(3);
        check_idle_outputs("t7_after_reset");
        set_ready(1'b1);
        send_byte(8'h78, 1'b1, 1'b0);
        send_byte(8'h56, 1'b1, 1'b0);
        compare_all("t7");
        check("t7_value", {16'h0, got_q[got_q.size()-1]}, 32'h5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
